// File: rtl/ads8864_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ads8864_ctrl
// Purpose  : Conversion and serial-readout sequencer for one ADS8864 16-bit
//            SAR ADC. Pulses AD_CNVST, then clocks the result out of AD_SDOUT
//            (MSB first) and presents it as a parallel word with a one-cycle
//            valid strobe. Supports back-to-back continuous acquisition.
// Options  : ADS8864_BUSY_IND_EN - end the conversion on the ADC busy
//            indicator (AD_SDOUT low) instead of a fixed wait, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ads8864_ctrl #(
    parameter int CLK_DIV        = 2,
    parameter int CONV_CYCLES    = 140,
    parameter int DATA_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 280
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        CONT,
    output logic        AD_CNVST,
    output logic        AD_SCLK,
    input  logic        AD_SDOUT,
    output logic [15:0] DATA,
    output logic        DATA_VALID,
    output logic        BUSY,
    output logic [15:0] SAMPLE_CNT,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Reload value for the SCLK half-period counter and index of the last bit.
    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [4:0]  LAST_BIT = 5'(DATA_BITS - 1);

`ifdef ADS8864_BUSY_IND_EN
    // Conversion counter counts up from zero; TO_LAST is its value on the
    // final permitted conversion cycle.
    localparam logic [15:0] CONV_LOAD = 16'd0;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
`else
    // Conversion counter counts down to zero over exactly CONV_CYCLES cycles.
    localparam logic [15:0] CONV_LOAD = 16'(CONV_CYCLES - 1);
`endif

    state_t      state;
    logic [15:0] conv_cnt;
    logic [15:0] div_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;

    // Main sequencer: state, pin drive, serial capture and sample publishing.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            AD_CNVST   <= 1'b0;
            AD_SCLK    <= 1'b0;
            DATA       <= 16'd0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            SAMPLE_CNT <= 16'd0;
            conv_cnt   <= 16'd0;
            div_cnt    <= 16'd0;
            bit_cnt    <= 5'd0;
            shift_reg  <= 16'd0;
`ifdef ADS8864_BUSY_IND_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            DATA_VALID <= 1'b0;
`ifdef ADS8864_BUSY_IND_EN
            timeout_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state    <= S_CONV;
                        AD_CNVST <= 1'b1;
                        BUSY     <= 1'b1;
                        conv_cnt <= CONV_LOAD;
                    end
                end

                S_CONV: begin
`ifdef ADS8864_BUSY_IND_EN
                    // ADC signals end of conversion by pulling SDOUT low;
                    // ignore the first cycle while the pin settles.
                    if ((conv_cnt != 16'd0) && !AD_SDOUT) begin
                        state     <= S_READ;
                        AD_CNVST  <= 1'b0;
                        AD_SCLK   <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        bit_cnt   <= 5'd0;
                        shift_reg <= 16'd0;
                    end else if (conv_cnt == TO_LAST) begin
                        state     <= S_IDLE;
                        AD_CNVST  <= 1'b0;
                        BUSY      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        conv_cnt <= conv_cnt + 16'd1;
                    end
`else
                    if (conv_cnt == 16'd0) begin
                        state     <= S_READ;
                        AD_CNVST  <= 1'b0;
                        AD_SCLK   <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        bit_cnt   <= 5'd0;
                        shift_reg <= 16'd0;
                    end else begin
                        conv_cnt <= conv_cnt - 16'd1;
                    end
`endif
                end

                S_READ: begin
                    if (div_cnt != 16'd0) begin
                        div_cnt <= div_cnt - 16'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (!AD_SCLK) begin
                            // Rising SCLK edge: data has been stable since
                            // the previous falling edge, capture it now.
                            AD_SCLK   <= 1'b1;
                            shift_reg <= {shift_reg[14:0], AD_SDOUT};
                        end else begin
                            AD_SCLK <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                state      <= S_DONE;
                                DATA       <= shift_reg;
                                DATA_VALID <= 1'b1;
                                SAMPLE_CNT <= SAMPLE_CNT + 16'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (CONT) begin
                        state    <= S_CONV;
                        AD_CNVST <= 1'b1;
                        conv_cnt <= CONV_LOAD;
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ADS8864_BUSY_IND_EN
    assign TIMEOUT = timeout_q;
`else
    // No busy-indicator wait, so no timeout; TIMEOUT_CYCLES is never
    // negative, making this a constant 0.
    assign TIMEOUT = (TIMEOUT_CYCLES < 0);
`endif

endmodule
`default_nettype wire

// File: doc/ads8864_ctrl.md
# ads8864_ctrl

Sequencer for one ADS8864 16-bit SAR ADC on the serial interface. On request it drives AD_CNVST for the conversion window, then generates AD_SCLK and shifts in the result from AD_SDOUT, MSB first. It presents the sample as a parallel word with a one-cycle valid strobe and supports back-to-back continuous acquisition. It sits between the acquisition logic on SYSCLK and the ADC pins, or the ADS8864 model in simulation.

## Interface
- CLK_DIV, 2: SYSCLK cycles per AD_SCLK half-period (min 1); default gives 25 MHz at 100 MHz.
- CONV_CYCLES, 140: SYSCLK cycles AD_CNVST is held high (min 2); default is 1400 ns.
- DATA_BITS, 16: bits shifted per sample (1..16).
- TIMEOUT_CYCLES, 280: busy-indicator timeout, used only with ADS8864_BUSY_IND_EN.
- SYSCLK  in  1  100 MHz clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request one conversion; sampled only in IDLE.
- CONT  in  1  continuous mode; sampled in DONE.
- AD_CNVST  out  1  ADC convert start.
- AD_SCLK  out  1  ADC serial clock.
- AD_SDOUT  in  1  ADC serial data.
- DATA  out  16  last captured sample, right-justified, zero-extended above DATA_BITS.
- DATA_VALID  out  1  one-cycle strobe; DATA is new.
- BUSY  out  1  high in every state except IDLE.
- SAMPLE_CNT  out  16  count of DATA_VALID strobes; wraps FFFF->0000.
- TIMEOUT  out  1  one-cycle strobe on busy-indicator timeout.

## Operation
- FSM states: IDLE, CONV, READ, DONE.
- IDLE: AD_CNVST=0, AD_SCLK=0. If START=1, go to CONV.
- CONV:
  - AD_CNVST=1 for exactly CONV_CYCLES cycles (down-counter).
  - Then go to READ; AD_CNVST is 0 from the first READ cycle.
- READ: each bit is CLK_DIV cycles with AD_SCLK low, then CLK_DIV cycles high.
  - AD_SDOUT is captured into the shift register (shift left, LSB in) on the SYSCLK edge where AD_SCLK goes 0->1.
  - After the high phase of bit DATA_BITS, AD_SCLK returns to 0 and the FSM goes to DONE.
- DONE: lasts one cycle.
  - DATA <= shift register; DATA_VALID=1; SAMPLE_CNT+1.
  - If CONT=1, go to CONV; otherwise go to IDLE.
- START outside IDLE is ignored (not queued). START and CONT both high in IDLE behave as START.
- DATA holds its value until the next DONE.
- Arithmetic: bit counter 5 bits, CLK_DIV counter 16 bits, CONV/timeout counter 16 bits. Parameter values beyond these widths are illegal.

## Timing
- Reset values: AD_CNVST=0, AD_SCLK=0, DATA=0, DATA_VALID=0, BUSY=0, SAMPLE_CNT=0, TIMEOUT=0; state=IDLE.
- RESET mid-operation aborts on the same edge: pins go low and any partial sample is discarded.
- All outputs are registered.
- Latency: with START high at edge 0, AD_CNVST is high at edges 1..CONV_CYCLES.
  - DATA_VALID is high in cycle 1+CONV_CYCLES+2*CLK_DIV*DATA_BITS; 205 cycles with defaults.
- Continuous sample period: CONV_CYCLES+2*CLK_DIV*DATA_BITS+1 cycles; 205 cycles (2.05 us) with defaults.
- The AD_CNVST low time between samples in CONT mode is the READ+DONE duration, which is at least 3 cycles.

## Configuration
- Macro: ADS8864_BUSY_IND_EN.
- Defined: CONV exits on the first cycle, after at least 2 CONV cycles, in which AD_SDOUT is sampled 0 (busy indicator). CONV_CYCLES is ignored.
  - If no 0 is seen within TIMEOUT_CYCLES, AD_CNVST drops, TIMEOUT pulses for one cycle, and the FSM returns to IDLE with no DATA_VALID. CONT is ignored on timeout.
- Undefined: fixed CONV_CYCLES wait; AD_SDOUT is ignored outside READ; TIMEOUT is tied to 0.

## Test plan
- Single shot, defaults, model returns 0xABCD:
  - START pulse at cycle 0 -> AD_CNVST high for 140 cycles.
  - Then 16 AD_SCLK periods of 4 cycles.
  - Then DATA=0xABCD, DATA_VALID at cycle 205, SAMPLE_CNT=1, BUSY low at cycle 206.
- CONT held high for 3 samples, model increments each sample -> DATA_VALID every 205 cycles; values 0xABCD, 0xABCE, 0xABCF.
- START pulsed during READ -> ignored; exactly one DATA_VALID.
- RESET asserted at cycle 100 of CONV -> on the next edge AD_CNVST=0, BUSY=0, no DATA_VALID; DATA keeps its reset value 0.
- CLK_DIV=1, DATA_BITS=12, serial pattern 0xA5A -> DATA=0x0A5A.
- With ADS8864_BUSY_IND_EN, AD_SDOUT held 1 -> TIMEOUT pulse at cycle 281, state IDLE, SAMPLE_CNT unchanged.
